// File: rtl/ternary_dot_accumulator.sv
// Reduction stage for the ternary-multiply array: sums LANES signed 8-bit products per beat
// over a VEC_LEN-element vector and hands the dot product downstream over valid/ready.
module ternary_dot_accumulator #(
    parameter int LANES   = 16,
    parameter int VEC_LEN = 4096,
    parameter int ACC_W   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*8-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_err
);

    localparam int BEATS  = VEC_LEN / LANES;
    localparam int LSUM_W = 8 + $clog2(LANES);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    function automatic logic signed [LSUM_W-1:0] lane_sum(input logic [LANES*8-1:0] d);
        logic signed [LSUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            s = s + LSUM_W'(signed'(d[8*i +: 8]));
        end
        return s;
    endfunction

    state_e                    state_q,    state_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic signed [LSUM_W-1:0]  s1_sum_q,   s1_sum_d;
    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_final_q, s1_final_d;
    logic                      s1_err_q,   s1_err_d;
    logic signed [ACC_W-1:0]   acc_q,      acc_d;
    logic [ACC_W-1:0]          out_sum_q,  out_sum_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_err_q,  out_err_d;
    logic                      in_ready_q, in_ready_d;

    logic                      beat_acc_s;
    logic                      at_last_beat_s;
    logic                      beat_final_s;
    logic signed [ACC_W-1:0]   acc_sum_s;

    // Next-state logic for stage 1, stage 2, beat counter and the output FSM.
    always_comb begin
        beat_acc_s     = in_valid && in_ready_q;
        at_last_beat_s = (beat_cnt_q == LAST_BEAT);
        beat_final_s   = in_last || at_last_beat_s;
        acc_sum_s      = acc_q + ACC_W'(s1_sum_q);

        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        s1_sum_d    = s1_sum_q;
        s1_valid_d  = beat_acc_s;
        s1_final_d  = s1_final_q;
        s1_err_d    = s1_err_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;

        if (beat_acc_s) begin
            s1_sum_d   = lane_sum(in_data);
            s1_final_d = beat_final_s;
            s1_err_d   = in_last ^ at_last_beat_s;
            if (beat_final_s) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        // A final entry closes the frame: capture the total and restart the accumulator.
        if (s1_valid_q) begin
            if (s1_final_q) begin
                out_sum_d = acc_sum_s;
                out_err_d = s1_err_q;
                acc_d     = '0;
            end else begin
                acc_d = acc_sum_s;
            end
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_ACCUM: begin
                if (beat_acc_s && beat_final_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        in_ready_d = (state_d == ST_ACCUM);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            beat_cnt_q  <= '0;
            s1_sum_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_final_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            s1_sum_q    <= s1_sum_d;
            s1_valid_q  <= s1_valid_d;
            s1_final_q  <= s1_final_d;
            s1_err_q    <= s1_err_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ternary_dot_accumulator.sv
// Directed bench for ternary_dot_accumulator: framed vectors with hand-computed dot products,
// latency, back-pressure, framing errors and mid-frame reset.
module tb_ternary_dot_accumulator;

    localparam int LANES   = 16;
    localparam int VEC_LEN = 4096;
    localparam int ACC_W   = 20;
    localparam int TO      = 400;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*8-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;
    logic                 out_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ternary_dot_accumulator #(
        .LANES   (LANES),
        .VEC_LEN (VEC_LEN),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sum_i();
        return int'(signed'(out_sum));
    endfunction

    function automatic logic [LANES*8-1:0] make_beat(input int v, input bit alt);
        logic [LANES*8-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            d[8*i +: 8] = (alt && (i % 2 == 1)) ? 8'(-v) : 8'(v);
        end
        return d;
    endfunction

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = {4{32'($urandom)}};
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [LANES*8-1:0] d, input logic last);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && g < TO) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= TO) begin
            n_fail++;
            $error("FAIL beat_timeout: in_ready stayed 0 for %0d cycles", g);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int v, input bit alt, input int nbeats,
                              input bit mark_last, input bit bubbles);
        for (int k = 0; k < nbeats; k++) begin
            if (bubbles && $urandom_range(0, 9) < 3) begin
                for (int b = 0; b < int'($urandom_range(1, 3)); b++) idle_cycle();
            end
            send_beat(make_beat(v, alt), mark_last && (k == nbeats - 1));
        end
    endtask

    task automatic expect_result(input string tag, input int exp_sum, input int exp_err);
        int g = 0;
        while (!out_valid && g < TO) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= TO) begin
            n_fail++;
            $error("FAIL %s_timeout: out_valid stayed 0 for %0d cycles", tag, g);
        end
        check({tag, "_sum"}, sum_i(), exp_sum);
        check({tag, "_err"}, int'(out_err), exp_err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", sum_i(), 0);
        check("rst_out_err", int'(out_err), 0);

        // All +1 with latency check: final beat accepted at edge t, valid after t+2.
        send_frame(1, 1'b0, 256, 1'b1, 1'b0);
        check("lat_t0_valid", int'(out_valid), 0);
        check("lat_t0_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        check("lat_t1_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_t2_valid", int'(out_valid), 1);
        expect_result("ones", 4096, 0);

        send_frame(-128, 1'b0, 256, 1'b1, 1'b0);
        expect_result("neg128", -524288, 0);
        send_frame(127, 1'b0, 256, 1'b1, 1'b0);
        expect_result("pos127", 520192, 0);

        send_frame(5, 1'b1, 256, 1'b1, 1'b1);
        expect_result("alt5_bubbles", 0, 0);

        // Back-pressure: result held, input blocked even with in_valid asserted.
        send_frame(3, 1'b0, 256, 1'b1, 1'b0);
        while (!out_valid) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = make_beat(100, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_sum", sum_i(), 12288);
            check("hold_err", int'(out_err), 0);
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        expect_result("hold_release", 12288, 0);
        send_frame(2, 1'b0, 256, 1'b1, 1'b0);
        expect_result("twos", 8192, 0);

        send_frame(1, 1'b0, 10, 1'b1, 1'b0);
        expect_result("early_last", 160, 1);
        send_frame(1, 1'b0, 256, 1'b1, 1'b0);
        expect_result("after_early", 4096, 0);

        send_frame(1, 1'b0, 256, 1'b0, 1'b0);
        expect_result("missing_last", 4096, 1);
        send_frame(2, 1'b0, 256, 1'b1, 1'b0);
        expect_result("after_missing", 8192, 0);

        // Reset asserted for one edge while beat 100 is being offered.
        send_frame(1, 1'b0, 100, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = make_beat(1, 1'b0);
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_sum", sum_i(), 0);
        check("midrst_out_err", int'(out_err), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        send_frame(1, 1'b0, 256, 1'b1, 1'b0);
        expect_result("after_reset", 4096, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
